// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line in, received word and frame status out
interface uart_rx_frame_if #(parameter int DATA_BITS = 8);
  logic                 data_rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 active_flag;
  logic                 done_flag;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_flag;
  modport master (output data_rx, input data_out, active_flag, done_flag, parity_err, frame_err, break_flag);
  modport slave  (input data_rx, output data_out, active_flag, done_flag, parity_err, frame_err, break_flag);
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver with mid-bit sampling, parity/stop checks and break detection
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter bit PARITY_EN  = 1,
  parameter bit PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           baud_clk,
  input  logic           reset,
  uart_rx_frame_if.slave bus
);
  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVS / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t               state, state_n;
  logic                 s1, s2;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic                 stop_cnt, stop_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n, data_out, dout_n;
  logic                 xor_acc, xor_n, perr, perr_n, ferr, ferr_n, ones, ones_n;
  logic                 active_flag, act_n, done_flag, done_n;
  logic                 parity_err, pe_n, frame_err, fe_n, break_flag, bk_n;
  logic                 line, samp;

  assign line = s2;
  assign samp = tick_cnt == T_LAST;

  always_comb begin
    state_n = state;
    tick_n  = samp ? '0 : tick_cnt + 1'b1;
    bit_n   = bit_cnt;
    stop_n  = stop_cnt;
    shift_n = shift_reg;
    xor_n   = xor_acc;
    perr_n  = perr;
    ferr_n  = ferr;
    ones_n  = ones;
    dout_n  = data_out;
    act_n   = active_flag;
    done_n  = 1'b0;
    pe_n    = parity_err;
    fe_n    = frame_err;
    bk_n    = break_flag;
    case (state)
      IDLE: begin
        {pe_n, fe_n, bk_n, act_n} = 4'b0;
        tick_n = '0;
        if (!line) begin
          state_n = START;
          act_n   = 1'b1;
        end
      end
      START: begin
        tick_n = tick_cnt + 1'b1;
        if (tick_cnt == T_MID) begin
          tick_n = '0;
          if (line) begin
            state_n = IDLE;
            act_n   = 1'b0;
          end else begin
            state_n = DATA;
            bit_n   = '0;
            {xor_n, perr_n, ferr_n, ones_n} = 4'b0;
          end
        end
      end
      DATA: if (samp) begin
        shift_n = {line, shift_reg[DATA_BITS-1:1]};
        xor_n   = xor_acc ^ line;
        ones_n  = ones | line;
        bit_n   = bit_cnt + 1'b1;
        stop_n  = 1'b0;
        if (bit_cnt == B_LAST) state_n = PARITY_EN ? PARITY : STOP;
      end
      PARITY: if (samp) begin
        perr_n  = xor_acc ^ line ^ PARITY_ODD;
        ones_n  = ones | line;
        state_n = STOP;
      end
      STOP: if (samp) begin
        ferr_n = ferr | !line;
        ones_n = ones | line;
        stop_n = stop_cnt + 1'b1;
        // status is published from the latches so it appears only alongside done
        if (stop_cnt == S_LAST) begin
          done_n  = 1'b1;
          dout_n  = shift_reg;
          pe_n    = perr;
          fe_n    = ferr | !line;
          bk_n    = !(ones | line);
          act_n   = 1'b0;
          state_n = line ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: state_n = line ? IDLE : WAIT_HIGH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset)
    if (!reset) begin
      {s1, s2}    <= 2'b11;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shift_reg   <= '0;
      {xor_acc, perr, ferr, ones} <= 4'b0;
      data_out    <= '0;
      active_flag <= 1'b0;
      done_flag   <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_flag  <= 1'b0;
    end else begin
      {s1, s2}    <= {bus.data_rx, s1};
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      stop_cnt    <= stop_n;
      shift_reg   <= shift_n;
      {xor_acc, perr, ferr, ones} <= {xor_n, perr_n, ferr_n, ones_n};
      data_out    <= dout_n;
      active_flag <= act_n;
      done_flag   <= done_n;
      parity_err  <= pe_n;
      frame_err   <= fe_n;
      break_flag  <= bk_n;
    end

  assign bus.data_out    = data_out;
  assign bus.active_flag = active_flag;
  assign bus.done_flag   = done_flag;
  assign bus.parity_err  = parity_err;
  assign bus.frame_err   = frame_err;
  assign bus.break_flag  = break_flag;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames on a default receiver and a 7N2 receiver
module tb_uart_rx_frame;
  logic baud_clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n1 = 0, n2 = 0, base;
  logic [7:0] d1;
  logic [6:0] d2;
  logic pe1, fe1, bk1, fe2, bk2;

  always #5 baud_clk = ~baud_clk;

  uart_rx_frame_if #(.DATA_BITS(8)) bus1 ();
  uart_rx_frame_if #(.DATA_BITS(7)) bus2 ();

  uart_rx_frame dut1 (.baud_clk(baud_clk), .reset(reset), .bus(bus1.slave));
  uart_rx_frame #(.DATA_BITS(7), .OVS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dut2 (.baud_clk(baud_clk), .reset(reset), .bus(bus2.slave));

  always @(negedge baud_clk) begin
    if (bus1.done_flag) begin
      n1++;
      d1 = bus1.data_out; pe1 = bus1.parity_err; fe1 = bus1.frame_err; bk1 = bus1.break_flag;
    end
    if (bus2.done_flag) begin
      n2++;
      d2 = bus2.data_out; fe2 = bus2.frame_err; bk2 = bus2.break_flag;
    end
  end

  task automatic drive1(input logic v, input int n);
    bus1.data_rx = v;
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic send1(input logic [7:0] d, input logic par, input logic stp);
    drive1(1'b0, 16);
    for (int i = 0; i < 8; i++) drive1(d[i], 16);
    drive1(par, 16);
    drive1(stp, 16);
    bus1.data_rx = 1'b1;
  endtask

  task automatic send2(input logic [6:0] d, input logic st1, input logic st2);
    bus2.data_rx = 1'b0;
    repeat (8) @(negedge baud_clk);
    for (int i = 0; i < 7; i++) begin
      bus2.data_rx = d[i];
      repeat (8) @(negedge baud_clk);
    end
    bus2.data_rx = st1;
    repeat (8) @(negedge baud_clk);
    bus2.data_rx = st2;
    repeat (8) @(negedge baud_clk);
    bus2.data_rx = 1'b1;
  endtask

  task automatic test_reset;
    bus1.data_rx = 1'b1;
    bus2.data_rx = 1'b1;
    repeat (3) @(negedge baud_clk);
    checks++; if (bus1.data_out !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", bus1.data_out); end
    checks++; if (bus1.active_flag !== 1'b0) begin errors++; $display("FAIL rst_active got=%b exp=0", bus1.active_flag); end
    checks++; if (bus1.done_flag !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus1.done_flag); end
    checks++; if (bus1.parity_err !== 1'b0) begin errors++; $display("FAIL rst_perr got=%b exp=0", bus1.parity_err); end
    checks++; if (bus1.frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr got=%b exp=0", bus1.frame_err); end
    checks++; if (bus1.break_flag !== 1'b0) begin errors++; $display("FAIL rst_break got=%b exp=0", bus1.break_flag); end
    reset = 1'b1;
    repeat (4) @(negedge baud_clk);
  endtask

  task automatic test_good_frame;
    base = n1;
    send1(8'hA5, 1'b0, 1'b1);
    repeat (4) @(negedge baud_clk);
    checks++; if (n1 !== base + 1) begin errors++; $display("FAIL a5_done_count got=%0d exp=%0d", n1 - base, 1); end
    checks++; if (d1 !== 8'hA5) begin errors++; $display("FAIL a5_data got=%h exp=a5", d1); end
    checks++; if (pe1 !== 1'b0) begin errors++; $display("FAIL a5_perr got=%b exp=0", pe1); end
    checks++; if (fe1 !== 1'b0) begin errors++; $display("FAIL a5_ferr got=%b exp=0", fe1); end
    checks++; if (bk1 !== 1'b0) begin errors++; $display("FAIL a5_break got=%b exp=0", bk1); end
    checks++; if (bus1.done_flag !== 1'b0) begin errors++; $display("FAIL a5_done_low got=%b exp=0", bus1.done_flag); end
  endtask

  task automatic test_parity_err;
    base = n1;
    send1(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge baud_clk);
    checks++; if (n1 !== base + 1) begin errors++; $display("FAIL par_done_count got=%0d exp=%0d", n1 - base, 1); end
    checks++; if (d1 !== 8'h07) begin errors++; $display("FAIL par_data got=%h exp=07", d1); end
    checks++; if (pe1 !== 1'b1) begin errors++; $display("FAIL par_perr got=%b exp=1", pe1); end
    checks++; if (fe1 !== 1'b0) begin errors++; $display("FAIL par_ferr got=%b exp=0", fe1); end
  endtask

  task automatic test_false_start;
    base = n1;
    drive1(1'b0, 4);
    checks++; if (bus1.active_flag !== 1'b1) begin errors++; $display("FAIL fs_active_rise got=%b exp=1", bus1.active_flag); end
    drive1(1'b1, 12);
    checks++; if (bus1.active_flag !== 1'b0) begin errors++; $display("FAIL fs_active_fall got=%b exp=0", bus1.active_flag); end
    repeat (200) @(negedge baud_clk);
    checks++; if (n1 !== base) begin errors++; $display("FAIL fs_no_done got=%0d exp=0", n1 - base); end
    checks++; if (bus1.data_out !== 8'h07) begin errors++; $display("FAIL fs_data_held got=%h exp=07", bus1.data_out); end
  endtask

  task automatic test_break;
    base = n1;
    drive1(1'b0, 3 * 11 * 16);
    checks++; if (n1 !== base + 1) begin errors++; $display("FAIL brk_done_count got=%0d exp=%0d", n1 - base, 1); end
    checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL brk_data got=%h exp=00", d1); end
    checks++; if (fe1 !== 1'b1) begin errors++; $display("FAIL brk_ferr got=%b exp=1", fe1); end
    checks++; if (bk1 !== 1'b1) begin errors++; $display("FAIL brk_break got=%b exp=1", bk1); end
    checks++; if (bus1.active_flag !== 1'b0) begin errors++; $display("FAIL brk_active got=%b exp=0", bus1.active_flag); end
    drive1(1'b1, 20);
    send1(8'h5A, 1'b0, 1'b1);
    repeat (4) @(negedge baud_clk);
    checks++; if (n1 !== base + 2) begin errors++; $display("FAIL brk_after_count got=%0d exp=%0d", n1 - base, 2); end
    checks++; if (d1 !== 8'h5A) begin errors++; $display("FAIL brk_after_data got=%h exp=5a", d1); end
    checks++; if (fe1 !== 1'b0) begin errors++; $display("FAIL brk_after_ferr got=%b exp=0", fe1); end
    checks++; if (bk1 !== 1'b0) begin errors++; $display("FAIL brk_after_break got=%b exp=0", bk1); end
  endtask

  task automatic test_reset_midframe;
    base = n1;
    drive1(1'b0, 16);
    drive1(1'b0, 16);
    drive1(1'b0, 16);
    drive1(1'b1, 16);
    bus1.data_rx = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (bus1.data_out !== 8'h00) begin errors++; $display("FAIL mid_rst_data got=%h exp=00", bus1.data_out); end
    checks++; if (bus1.active_flag !== 1'b0) begin errors++; $display("FAIL mid_rst_active got=%b exp=0", bus1.active_flag); end
    @(negedge baud_clk);
    reset = 1'b1;
    repeat (200) @(negedge baud_clk);
    checks++; if (n1 !== base) begin errors++; $display("FAIL mid_rst_no_done got=%0d exp=0", n1 - base); end
    send1(8'hC3, 1'b0, 1'b1);
    repeat (4) @(negedge baud_clk);
    checks++; if (n1 !== base + 1) begin errors++; $display("FAIL c3_done_count got=%0d exp=%0d", n1 - base, 1); end
    checks++; if (d1 !== 8'hC3) begin errors++; $display("FAIL c3_data got=%h exp=c3", d1); end
    checks++; if (pe1 !== 1'b0) begin errors++; $display("FAIL c3_perr got=%b exp=0", pe1); end
  endtask

  task automatic test_back_to_back;
    base = n2;
    send2(7'h55, 1'b1, 1'b1);
    checks++; if (n2 !== base + 1) begin errors++; $display("FAIL b2b1_count got=%0d exp=%0d", n2 - base, 1); end
    checks++; if (d2 !== 7'h55) begin errors++; $display("FAIL b2b1_data got=%h exp=55", d2); end
    checks++; if (fe2 !== 1'b0) begin errors++; $display("FAIL b2b1_ferr got=%b exp=0", fe2); end
    send2(7'h2A, 1'b1, 1'b0);
    repeat (4) @(negedge baud_clk);
    checks++; if (n2 !== base + 2) begin errors++; $display("FAIL b2b2_count got=%0d exp=%0d", n2 - base, 2); end
    checks++; if (d2 !== 7'h2A) begin errors++; $display("FAIL b2b2_data got=%h exp=2a", d2); end
    checks++; if (fe2 !== 1'b1) begin errors++; $display("FAIL b2b2_ferr got=%b exp=1", fe2); end
    checks++; if (bk2 !== 1'b0) begin errors++; $display("FAIL b2b2_break got=%b exp=0", bk2); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_parity_err;
    test_false_start;
    test_break;
    test_reset_midframe;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Parametrised serial-to-parallel UART frame receiver; successor to the fixed 11-bit SIPO capture.
- Runs on an oversampled baud clock, samples mid-bit and supports configurable data width, optional parity and 1 or 2 stop bits.
- Validates the start bit, checks parity and stop bits, flags line breaks, and presents the data word with a one-cycle done strobe.
- Sits between the RX pin and the RX FIFO / register interface.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9, LSB transmitted first.
- OVS, 16, baud_clk ticks per bit period, legal 4..16.
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity; 1 = odd parity (ignored when PARITY_EN=0).
- STOP_BITS, 1, number of stop bits, legal 1 or 2.

Ports:
- baud_clk  input  1  oversampled bit clock, OVS ticks per bit; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_rx  input  1  serial line, idle high, asynchronous to baud_clk.
- data_out  output  DATA_BITS  last received data word.
- active_flag  output  1  high while a frame is being received (START through STOP).
- done_flag  output  1  one-cycle strobe; frame complete.
- parity_err  output  1  parity mismatch for the frame just completed; valid with done_flag.
- frame_err  output  1  a stop bit was sampled low; valid with done_flag.
- break_flag  output  1  all data, parity and stop samples were 0; valid with done_flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0; data_out = 0.
  - State = IDLE, counters = 0.
  - Synchroniser flops reset to 1 (line idle).
- Input path: data_rx passes through a 2-flop synchroniser. All references to "line" below mean the synchronised value, which lags the pin by 2 cycles.
- Counters:
  - tick_cnt counts 0..OVS-1.
  - bit_cnt counts 0..DATA_BITS-1.
  - stop_cnt counts 0..STOP_BITS-1.
  - A sample is taken when tick_cnt reaches OVS-1, except in START.
- IDLE:
  - active_flag=0; done_flag, parity_err, frame_err and break_flag are cleared every cycle.
  - On line=0: go to START, tick_cnt=0, active_flag=1.
- START:
  - Count to (OVS/2)-1, which is mid start bit.
  - If the line is 1 at that point, it is a false start: return to IDLE with no done_flag.
  - Otherwise go to DATA with tick_cnt=0 and bit_cnt=0.
- DATA:
  - At each sample, shift the line into shift_reg[bit_cnt] (LSB first) and accumulate XOR parity.
  - After sample DATA_BITS-1, go to PARITY if PARITY_EN, else go to STOP.
- PARITY:
  - At the sample, compute parity_err = (xor_data ^ sample ^ PARITY_ODD).
  - Go to STOP.
- STOP:
  - At each sample, any 0 sets the frame-error latch.
  - After sample STOP_BITS-1, on the following cycle:
    - data_out ← shift_reg.
    - done_flag=1 for exactly one cycle.
    - parity_err, frame_err and break_flag are valid in that same cycle.
    - active_flag ← 0.
  - Next state:
    - If the last stop sample was 1, go to IDLE.
    - Otherwise go to WAIT_HIGH.
- WAIT_HIGH:
  - Entered after a framing error or break.
  - No new start is accepted until the line has been 1 for at least one cycle; then go to IDLE.
  - Prevents retriggering on a stuck-low line.
- break_flag = 1 only when every sampled data, parity and stop bit was 0. frame_err is also 1 in that case.
- data_out holds its value between frames and changes only on a done_flag cycle. It is updated even when errors are flagged.
- Back-to-back frames: a start edge in the cycle after done_flag must be accepted; no idle gap is required beyond the stop bit(s).
- Reset mid-frame aborts immediately: no done_flag, and data_out returns to 0.
- Latency: done_flag rises one baud_clk after the final stop-bit sample tick, which is ~2 + OVS/2 + OVS×(frame bits−1) ticks after the falling edge on the pin.

Test Plan:
- Defaults, send 0xA5 with parity 0 and stop 1 → done_flag for 1 cycle; data_out=0xA5; parity_err=0, frame_err=0, break_flag=0.
- Defaults, send 0x07 with parity bit 0 (wrong, expected 1) → data_out=0x07, parity_err=1, frame_err=0.
- Line pulse low for OVS/4 ticks then high → active_flag rises, then falls by the mid start bit; no done_flag; data_out unchanged.
- Line held low 3 frame-lengths → one done_flag with data_out=0x00, frame_err=1, break_flag=1; no further done_flag until the line returns high and a new frame is sent.
- DATA_BITS=7, PARITY_EN=0, STOP_BITS=2: send 0x55 then 0x2A back-to-back; second stop bit low on frame 2 → two done_flags; data 0x55 then 0x2A; frame_err 0 then 1.
- Assert reset for 1 cycle mid-DATA of 0x3C, then send 0xC3 → no done for 0x3C; outputs 0 after reset; next done gives data_out=0xC3.
